// File: rtl/sm_mac_pkg.sv
// Shared types, constants and the sign-magnitude conversion helper for the
// sm_mac_pipe multiply/accumulate block.
package sm_mac_pkg;

    localparam int unsigned DEF_IN_DATA_WIDTH = 17;
    localparam int unsigned DEF_COEF_WIDTH    = 17;
    localparam int unsigned DEF_ACC_WIDTH     = 40;
    localparam int unsigned DEF_NUM_TAPS      = 8;
    localparam int unsigned DEF_PIPE_STAGES   = 3;

    localparam int unsigned PROD_WIDTH = DEF_IN_DATA_WIDTH + DEF_COEF_WIDTH - 1;
    localparam int unsigned CNT_WIDTH  = $clog2(DEF_NUM_TAPS + 1);

    // Widest magnitude the conversion helper handles.
    localparam int unsigned SM_MAX_WIDTH = 64;

    localparam logic MODE_PROD = 1'b0;
    localparam logic MODE_ACC  = 1'b1;

    typedef enum logic {
        StIdle,
        StAccum
    } group_state_e;

    // Magnitude is masked to 'width' bits; callers truncate the result to their
    // own two's-complement width. A negative zero comes out as exactly zero.
    function automatic logic [SM_MAX_WIDTH-1:0] sm_to_tc(
        input logic [SM_MAX_WIDTH-1:0] magnitude,
        input logic                    sign,
        input int unsigned             width
    );
        logic [SM_MAX_WIDTH-1:0] mask;
        logic [SM_MAX_WIDTH-1:0] mag;
        mask = (width >= SM_MAX_WIDTH) ? '1 : ((SM_MAX_WIDTH'(1) << width) - SM_MAX_WIDTH'(1));
        mag  = magnitude & mask;
        return sign ? (~mag + SM_MAX_WIDTH'(1)) : mag;
    endfunction

endpackage

// File: rtl/sm_mult_pipe.sv
// PIPE_STAGES-deep sign-magnitude multiplier: registered inputs, multiply, optional
// delay stages, then negate/extend. A sideband tag rides along with the valid bit.
module sm_mult_pipe
    import sm_mac_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int unsigned COEF_WIDTH    = DEF_COEF_WIDTH,
    parameter int unsigned OUT_WIDTH     = PROD_WIDTH + 1,
    parameter int unsigned PIPE_STAGES   = DEF_PIPE_STAGES,
    parameter int unsigned TAG_WIDTH     = CNT_WIDTH + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_en,
    input  logic                     i_vld,
    input  logic [IN_DATA_WIDTH-1:0] i_data,
    input  logic [COEF_WIDTH-1:0]    i_coef,
    input  logic [TAG_WIDTH-1:0]     i_tag,
    output logic                     o_vld,
    output logic [OUT_WIDTH-1:0]     o_prod,
    output logic [TAG_WIDTH-1:0]     o_tag
);

    localparam int unsigned ProdWidth = IN_DATA_WIDTH + COEF_WIDTH - 1;

    logic                     r_s1_vld;
    logic [IN_DATA_WIDTH-1:0] r_s1_data;
    logic [COEF_WIDTH-2:0]    r_s1_mag;
    logic                     r_s1_sign;
    logic [TAG_WIDTH-1:0]     r_s1_tag;

    logic [ProdWidth-1:0] w_mult;
    logic                 w_pre_vld;
    logic                 w_pre_sign;
    logic [ProdWidth-1:0] w_pre_mag;
    logic [TAG_WIDTH-1:0] w_pre_tag;

    logic                 r_out_vld;
    logic [OUT_WIDTH-1:0] r_out_prod;
    logic [TAG_WIDTH-1:0] r_out_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_vld  <= 1'b0;
            r_s1_data <= '0;
            r_s1_mag  <= '0;
            r_s1_sign <= 1'b0;
            r_s1_tag  <= '0;
        end else if (i_en) begin
            r_s1_vld  <= i_vld;
            r_s1_data <= i_data;
            r_s1_mag  <= i_coef[COEF_WIDTH-2:0];
            r_s1_sign <= i_coef[COEF_WIDTH-1];
            r_s1_tag  <= i_tag;
        end
    end

    assign w_mult = ProdWidth'(r_s1_data) * ProdWidth'(r_s1_mag);

    generate
        if (PIPE_STAGES == 2) begin : g_no_mid
            assign w_pre_vld  = r_s1_vld;
            assign w_pre_sign = r_s1_sign;
            assign w_pre_mag  = w_mult;
            assign w_pre_tag  = r_s1_tag;
        end else begin : g_mid
            localparam int unsigned MidStages = PIPE_STAGES - 2;
            logic                 r_vld  [MidStages];
            logic                 r_sign [MidStages];
            logic [ProdWidth-1:0] r_mag  [MidStages];
            logic [TAG_WIDTH-1:0] r_tag  [MidStages];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < MidStages; i++) begin
                        r_vld[i]  <= 1'b0;
                        r_sign[i] <= 1'b0;
                        r_mag[i]  <= '0;
                        r_tag[i]  <= '0;
                    end
                end else if (i_en) begin
                    r_vld[0]  <= r_s1_vld;
                    r_sign[0] <= r_s1_sign;
                    r_mag[0]  <= w_mult;
                    r_tag[0]  <= r_s1_tag;
                    for (int i = 1; i < MidStages; i++) begin
                        r_vld[i]  <= r_vld[i-1];
                        r_sign[i] <= r_sign[i-1];
                        r_mag[i]  <= r_mag[i-1];
                        r_tag[i]  <= r_tag[i-1];
                    end
                end
            end

            assign w_pre_vld  = r_vld[MidStages-1];
            assign w_pre_sign = r_sign[MidStages-1];
            assign w_pre_mag  = r_mag[MidStages-1];
            assign w_pre_tag  = r_tag[MidStages-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld  <= 1'b0;
            r_out_prod <= '0;
            r_out_tag  <= '0;
        end else if (i_en) begin
            r_out_vld  <= w_pre_vld;
            r_out_prod <= OUT_WIDTH'(sm_to_tc(SM_MAX_WIDTH'(w_pre_mag), w_pre_sign, ProdWidth));
            r_out_tag  <= w_pre_tag;
        end
    end

    assign o_vld  = r_out_vld;
    assign o_prod = r_out_prod;
    assign o_tag  = r_out_tag;

endmodule

// File: rtl/sm_mac_pipe.sv
// Sign-magnitude multiply with optional group accumulation, valid/ready
// handshake with a single global stall, and sticky per-group overflow.
module sm_mac_pipe
    import sm_mac_pkg::*;
#(
    parameter int unsigned IN_DATA_WIDTH = DEF_IN_DATA_WIDTH,
    parameter int unsigned COEF_WIDTH    = DEF_COEF_WIDTH,
    parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int unsigned NUM_TAPS      = DEF_NUM_TAPS,
    parameter int unsigned PIPE_STAGES   = DEF_PIPE_STAGES
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_data_vld,
    output logic                           in_ready,
    input  logic [IN_DATA_WIDTH-1:0]       in_data,
    input  logic [COEF_WIDTH-1:0]          coef,
    input  logic                           in_last,
    input  logic                           mode,
    output logic [ACC_WIDTH-1:0]           out_data,
    output logic                           out_data_vld,
    input  logic                           out_ready,
    output logic [$clog2(NUM_TAPS+1)-1:0]  out_count,
    output logic                           out_ovf
);

    localparam int unsigned CntWidth = $clog2(NUM_TAPS + 1);
    localparam int unsigned TagWidth = CntWidth + 2;

    group_state_e        r_state, w_state_d;
    logic                r_mode;
    logic [CntWidth-1:0] r_tap_cnt;

    logic                w_stall, w_accept, w_first, w_mode_eff, w_close;
    logic [CntWidth-1:0] w_beat_cnt;
    logic [TagWidth-1:0] w_tag_in, w_p_tag;

    logic                 w_p_vld, w_p_first, w_p_close;
    logic [CntWidth-1:0]  w_p_cnt;
    logic [ACC_WIDTH-1:0] w_p_prod, w_sum, w_acc_d;
    logic                 w_add_ovf, w_ovf_d, w_load;

    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_acc_ovf;
    logic [ACC_WIDTH-1:0] r_out_data;
    logic                 r_out_vld;
    logic [CntWidth-1:0]  r_out_cnt;
    logic                 r_out_ovf;

    assign w_stall  = r_out_vld && !out_ready;
    assign in_ready = !w_stall;
    assign w_accept = in_data_vld && in_ready;

    // Group bookkeeping happens at the input so each beat carries its own
    // first/close/count flags down the product pipeline.
    always_comb begin
        w_first    = (r_state == StIdle);
        w_mode_eff = w_first ? mode : r_mode;
        w_beat_cnt = w_first ? CntWidth'(1) : r_tap_cnt + CntWidth'(1);
        w_close    = (w_mode_eff == MODE_PROD) || in_last
                     || (w_beat_cnt == CntWidth'(NUM_TAPS));
        w_state_d  = r_state;
        if (w_accept) begin
            w_state_d = w_close ? StIdle : StAccum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_mode    <= MODE_PROD;
            r_tap_cnt <= '0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                if (w_first) begin
                    r_mode <= mode;
                end
                r_tap_cnt <= w_close ? '0 : w_beat_cnt;
            end
        end
    end

    assign w_tag_in = {w_first, w_close, w_beat_cnt};

    sm_mult_pipe #(
        .IN_DATA_WIDTH (IN_DATA_WIDTH),
        .COEF_WIDTH    (COEF_WIDTH),
        .OUT_WIDTH     (ACC_WIDTH),
        .PIPE_STAGES   (PIPE_STAGES),
        .TAG_WIDTH     (TagWidth)
    ) u_mult (
        .clk    (clk),
        .reset  (reset),
        .i_en   (!w_stall),
        .i_vld  (w_accept),
        .i_data (in_data),
        .i_coef (coef),
        .i_tag  (w_tag_in),
        .o_vld  (w_p_vld),
        .o_prod (w_p_prod),
        .o_tag  (w_p_tag)
    );

    assign {w_p_first, w_p_close, w_p_cnt} = w_p_tag;

    always_comb begin
        w_sum     = r_acc + w_p_prod;
        w_add_ovf = (r_acc[ACC_WIDTH-1] == w_p_prod[ACC_WIDTH-1])
                    && (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
        w_acc_d   = w_p_first ? w_p_prod : w_sum;
        w_ovf_d   = w_p_first ? 1'b0 : (r_acc_ovf || w_add_ovf);
        w_load    = w_p_vld && !w_stall && w_p_close;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_acc_ovf  <= 1'b0;
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
            r_out_cnt  <= '0;
            r_out_ovf  <= 1'b0;
        end else begin
            if (w_p_vld && !w_stall) begin
                r_acc     <= w_acc_d;
                r_acc_ovf <= w_ovf_d;
            end
            if (w_load) begin
                r_out_data <= w_acc_d;
                r_out_cnt  <= w_p_cnt;
                r_out_ovf  <= w_ovf_d;
                r_out_vld  <= 1'b1;
            end else if (out_ready) begin
                r_out_vld <= 1'b0;
            end
        end
    end

    assign out_data     = r_out_data;
    assign out_data_vld = r_out_vld;
    assign out_count    = r_out_cnt;
    assign out_ovf      = r_out_ovf;

endmodule

// File: tb/tb_sm_mac_pipe.sv
// Bench for sm_mac_pipe: directed cases plus randomized traffic against a
// transaction-level model, on a 40-bit and a 34-bit accumulator instance.
module tb_sm_mac_pipe;

    logic        clk = 1'b0;
    logic        reset, in_data_vld, in_ready, in_last, mode, out_ready;
    logic [16:0] in_data, coef;
    logic [39:0] out_data;
    logic        out_data_vld, out_ovf;
    logic [3:0]  out_count;
    logic        in_ready34, out_data_vld34, out_ovf34;
    logic [33:0] out_data34;
    logic [3:0]  out_count34;

    typedef struct packed {
        logic [39:0] d;
        logic [3:0]  c;
        logic        o;
    } res_t;

    res_t exp40[$], exp34[$], obs40[$], obs34[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: one open group at a time.
    bit     m_busy, m_mode, m_ovf40, m_ovf34;
    int     m_cnt;
    longint m_acc40, m_acc34;

    always #5 clk = ~clk;

    sm_mac_pipe u_dut (
        .clk(clk), .reset(reset), .in_data_vld(in_data_vld), .in_ready(in_ready),
        .in_data(in_data), .coef(coef), .in_last(in_last), .mode(mode),
        .out_data(out_data), .out_data_vld(out_data_vld), .out_ready(out_ready),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    sm_mac_pipe #(.ACC_WIDTH(34)) u_dut34 (
        .clk(clk), .reset(reset), .in_data_vld(in_data_vld), .in_ready(in_ready34),
        .in_data(in_data), .coef(coef), .in_last(in_last), .mode(mode),
        .out_data(out_data34), .out_data_vld(out_data_vld34), .out_ready(out_ready),
        .out_count(out_count34), .out_ovf(out_ovf34)
    );

    function automatic longint wrap_s(input longint v, input int w);
        longint m;
        m = v & ((longint'(1) << w) - 1);
        if (m >= (longint'(1) << (w - 1))) m = m - (longint'(1) << w);
        return m;
    endfunction

    function automatic bit out_of_range(input longint v, input int w);
        return (v > (longint'(1) << (w - 1)) - 1) || (v < -(longint'(1) << (w - 1)));
    endfunction

    task automatic model_beat(input logic [16:0] d, input logic [16:0] c, input bit last,
                              input bit md);
        longint p;
        res_t   r;
        p = longint'(d) * longint'(c[15:0]);
        if (c[16]) p = -p;
        if (!m_busy) begin
            m_busy = 1; m_mode = md; m_cnt = 0;
            m_acc40 = wrap_s(p, 40); m_acc34 = wrap_s(p, 34);
            m_ovf40 = 0; m_ovf34 = 0;
        end else begin
            m_ovf40 = m_ovf40 | out_of_range(m_acc40 + p, 40);
            m_ovf34 = m_ovf34 | out_of_range(m_acc34 + p, 34);
            m_acc40 = wrap_s(m_acc40 + p, 40);
            m_acc34 = wrap_s(m_acc34 + p, 34);
        end
        m_cnt++;
        if (m_mode == 0 || last || m_cnt == 8) begin
            r.d = 40'(m_acc40); r.c = 4'(m_cnt); r.o = m_ovf40;
            exp40.push_back(r);
            r.d = {6'b0, 34'(m_acc34)}; r.c = 4'(m_cnt); r.o = m_ovf34;
            exp34.push_back(r);
            m_busy = 0;
        end
    endtask

    task automatic clear_q();
        exp40.delete(); exp34.delete(); obs40.delete(); obs34.delete();
    endtask

    // One clock: drive inputs after the edge, then record what will transfer at the next edge.
    task automatic step(input bit rst, input bit vld, input logic [16:0] d, input logic [16:0] c,
                        input bit last, input bit md, input bit rdy);
        res_t r;
        @(posedge clk);
        #1;
        reset = rst; in_data_vld = vld; in_data = d; coef = c;
        in_last = last; mode = md; out_ready = rdy;
        #1;
        if (rst) begin
            clear_q();
            m_busy = 0;
        end else begin
            if (in_data_vld && in_ready) model_beat(d, c, last, md);
            if (out_data_vld && out_ready) begin
                r.d = out_data; r.c = out_count; r.o = out_ovf;
                obs40.push_back(r);
            end
            if (out_data_vld34 && out_ready) begin
                r.d = {6'b0, out_data34}; r.c = out_count34; r.o = out_ovf34;
                obs34.push_back(r);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0, '0, 0, 0, 1);
    endtask

    task automatic test_reset();
        repeat (3) step(1, 0, '0, '0, 0, 0, 1);
        step(0, 0, '0, '0, 0, 0, 1);
        n_vec++; if (out_data !== 40'd0) begin n_err++; $display("FAIL reset_data: got %0h want 0", out_data); end
        n_vec++; if (out_data_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", out_data_vld); end
        n_vec++; if (out_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", out_count); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", out_ovf); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_data34 !== 34'd0) begin n_err++; $display("FAIL reset_data34: got %0h want 0", out_data34); end
        n_vec++; if (in_ready34 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready34: got %b want 1", in_ready34); end
    endtask

    task automatic test_mode0_max();
        logic [39:0] want;
        logic [39:0] got_d;
        logic [3:0]  got_c;
        logic        got_o;
        int          lat;
        want = -40'sd8589737985;
        got_d = 'x; got_c = 'x; got_o = 'x;
        clear_q();
        step(0, 1, 17'd131071, 17'd131071, 0, 0, 1);
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step(0, 0, '0, '0, 0, 0, 1);
            if (lat < 0 && out_data_vld === 1'b1) begin
                lat = k; got_d = out_data; got_c = out_count; got_o = out_ovf;
            end
        end
        n_vec++; if (lat != 4) begin n_err++; $display("FAIL m0_latency: got %0d want 4", lat); end
        n_vec++; if (got_d !== want) begin n_err++; $display("FAIL m0_max_data: got %0h want %0h", got_d, want); end
        n_vec++; if (got_c !== 4'd1) begin n_err++; $display("FAIL m0_max_count: got %0d want 1", got_c); end
        n_vec++; if (got_o !== 1'b0) begin n_err++; $display("FAIL m0_max_ovf: got %b want 0", got_o); end
        n_vec++; if (obs40.size() != 1) begin n_err++; $display("FAIL m0_max_results: got %0d want 1", obs40.size()); end
    endtask

    task automatic test_acc_group();
        logic [16:0] cs [4];
        cs[0] = 17'h00003; cs[1] = 17'h10005; cs[2] = 17'h00007; cs[3] = 17'h10001;
        clear_q();
        for (int i = 0; i < 4; i++) step(0, 1, 17'd100, cs[i], i == 3, 1, 1);
        idle(10);
        n_vec++; if (obs40.size() != 1) begin n_err++; $display("FAIL acc_results: got %0d want 1", obs40.size()); end
        if (obs40.size() >= 1) begin
            n_vec++; if (obs40[0].d !== 40'd400) begin n_err++; $display("FAIL acc_data: got %0d want 400", obs40[0].d); end
            n_vec++; if (obs40[0].c !== 4'd4) begin n_err++; $display("FAIL acc_count: got %0d want 4", obs40[0].c); end
            n_vec++; if (obs40[0].o !== 1'b0) begin n_err++; $display("FAIL acc_ovf: got %b want 0", obs40[0].o); end
        end
    endtask

    task automatic test_auto_close();
        clear_q();
        for (int i = 0; i < 9; i++) step(0, 1, 17'd1, 17'd1, i == 8, 1, 1);
        idle(10);
        n_vec++; if (obs40.size() != 2) begin n_err++; $display("FAIL auto_results: got %0d want 2", obs40.size()); end
        if (obs40.size() >= 2) begin
            n_vec++; if (obs40[0].d !== 40'd8) begin n_err++; $display("FAIL auto_data: got %0d want 8", obs40[0].d); end
            n_vec++; if (obs40[0].c !== 4'd8) begin n_err++; $display("FAIL auto_count: got %0d want 8", obs40[0].c); end
            n_vec++; if (obs40[1].d !== 40'd1) begin n_err++; $display("FAIL auto_next_data: got %0d want 1", obs40[1].d); end
            n_vec++; if (obs40[1].c !== 4'd1) begin n_err++; $display("FAIL auto_next_count: got %0d want 1", obs40[1].c); end
        end
    endtask

    task automatic test_neg_zero();
        clear_q();
        step(0, 1, 17'd5, 17'h10000, 0, 0, 1);
        idle(8);
        n_vec++; if (obs40.size() != 1) begin n_err++; $display("FAIL negzero_results: got %0d want 1", obs40.size()); end
        if (obs40.size() >= 1) begin
            n_vec++; if (obs40[0].d !== 40'd0) begin n_err++; $display("FAIL negzero_data: got %0h want 0", obs40[0].d); end
        end
    endtask

    task automatic compare_all(input string tag);
        n_vec++;
        if (obs40.size() != exp40.size()) begin
            n_err++; $display("FAIL %s_count40: got %0d results want %0d", tag, obs40.size(), exp40.size());
        end
        n_vec++;
        if (obs34.size() != exp34.size()) begin
            n_err++; $display("FAIL %s_count34: got %0d results want %0d", tag, obs34.size(), exp34.size());
        end
        for (int i = 0; i < obs40.size() && i < exp40.size(); i++) begin
            n_vec++;
            if (obs40[i] !== exp40[i]) begin
                n_err++;
                $display("FAIL %s_res40[%0d]: got d=%0h c=%0d o=%b want d=%0h c=%0d o=%b", tag, i,
                         obs40[i].d, obs40[i].c, obs40[i].o, exp40[i].d, exp40[i].c, exp40[i].o);
            end
        end
        for (int i = 0; i < obs34.size() && i < exp34.size(); i++) begin
            n_vec++;
            if (obs34[i] !== exp34[i]) begin
                n_err++;
                $display("FAIL %s_res34[%0d]: got d=%0h c=%0d o=%b want d=%0h c=%0d o=%b", tag, i,
                         obs34[i].d, obs34[i].c, obs34[i].o, exp34[i].d, exp34[i].c, exp34[i].o);
            end
        end
    endtask

    task automatic test_stall();
        logic [39:0] held;
        held = 'x;
        clear_q();
        for (int i = 0; i < 6; i++) step(0, 1, 17'($urandom), 17'($urandom), 0, 0, 1);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 17'($urandom), 17'($urandom), 0, 0, 0);
            if (k == 0) held = out_data;
            n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %b want 0", k, in_ready); end
            n_vec++; if (out_data_vld !== 1'b1) begin n_err++; $display("FAIL stall_vld[%0d]: got %b want 1", k, out_data_vld); end
            if (k > 0) begin
                n_vec++; if (out_data !== held) begin n_err++; $display("FAIL stall_hold[%0d]: got %0h want %0h", k, out_data, held); end
            end
        end
        for (int i = 0; i < 6; i++) step(0, 1, 17'($urandom), 17'($urandom), 0, 0, 1);
        idle(10);
        n_vec++; if (exp40.size() != 12) begin n_err++; $display("FAIL stall_beats: got %0d accepted want 12", exp40.size()); end
        compare_all("stall");
    endtask

    task automatic test_ovf();
        clear_q();
        step(0, 1, 17'd131071, 17'h0FFFF, 0, 1, 1);
        step(0, 1, 17'd131071, 17'h0FFFF, 1, 1, 1);
        idle(8);
        n_vec++; if (obs34.size() != 1) begin n_err++; $display("FAIL ovf_results: got %0d want 1", obs34.size()); end
        if (obs34.size() >= 1 && obs40.size() >= 1) begin
            n_vec++; if (obs34[0].d !== 40'd17179475970) begin n_err++; $display("FAIL ovf_data34: got %0d want 17179475970", obs34[0].d); end
            n_vec++; if (obs34[0].o !== 1'b1) begin n_err++; $display("FAIL ovf_flag34: got %b want 1", obs34[0].o); end
            n_vec++; if (obs34[0].c !== 4'd2) begin n_err++; $display("FAIL ovf_count34: got %0d want 2", obs34[0].c); end
            n_vec++; if (obs40[0].o !== 1'b0) begin n_err++; $display("FAIL ovf_flag40: got %b want 0", obs40[0].o); end
            n_vec++; if (obs40[0].d !== 40'd17179475970) begin n_err++; $display("FAIL ovf_data40: got %0d want 17179475970", obs40[0].d); end
        end
    endtask

    task automatic test_reset_mid_group();
        int seen;
        clear_q();
        step(0, 1, 17'd9, 17'd3, 0, 1, 1);
        step(1, 1, 17'd9, 17'd3, 0, 1, 1);
        step(0, 0, '0, '0, 0, 1, 1);
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, '0, '0, 0, 0, 1);
            if (out_data_vld !== 1'b0) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL rstmid_vld: got %0d valid cycles want 0", seen); end
        n_vec++; if (obs40.size() != 0) begin n_err++; $display("FAIL rstmid_results: got %0d want 0", obs40.size()); end
        n_vec++; if (out_data !== 40'd0) begin n_err++; $display("FAIL rstmid_data: got %0h want 0", out_data); end
        n_vec++; if (out_count !== 4'd0) begin n_err++; $display("FAIL rstmid_count: got %0d want 0", out_count); end
        n_vec++; if (out_ovf !== 1'b0) begin n_err++; $display("FAIL rstmid_ovf: got %b want 0", out_ovf); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_back_to_back();
        clear_q();
        for (int i = 0; i < 600; i++) begin
            step(0, ($urandom % 4) != 0, 17'($urandom), 17'($urandom), ($urandom % 4) == 0,
                 1'($urandom), ($urandom % 4) != 0);
        end
        // Close any open group so every accepted beat produces a result.
        step(0, 1, 17'd1, 17'd1, 1, 1, 1);
        idle(30);
        compare_all("random");
    endtask

    initial begin
        reset = 1'b1; in_data_vld = 1'b0; in_data = '0; coef = '0;
        in_last = 1'b0; mode = 1'b0; out_ready = 1'b1;
        m_busy = 0; m_mode = 0; m_cnt = 0; m_acc40 = 0; m_acc34 = 0; m_ovf40 = 0; m_ovf34 = 0;
        test_reset();
        test_mode0_max();
        test_acc_group();
        test_auto_close();
        test_neg_zero();
        test_stall();
        test_ovf();
        test_reset_mid_group();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sm_mac_pipe.md
Name: sm_mac_pipe

Overview:
- Parametrised successor to the single-product checksum multiplier.
- Multiplies an unsigned input sample by a sign-magnitude coefficient (MSB = sign, remaining bits = magnitude) to give a two's-complement product.
- Adds a pipelined product path, an optional accumulate mode that sums a group of beats (FIR tap accumulation), a valid/ready handshake with back-pressure, and sticky overflow reporting.
- Sits between the coefficient/sample sequencer and the FIR output formatter.

Parameters:
- IN_DATA_WIDTH, 17, unsigned sample width
- COEF_WIDTH, 17, sign-magnitude coefficient width; bit COEF_WIDTH-1 is the sign
- ACC_WIDTH, 40, accumulator/output width; must be >= IN_DATA_WIDTH+COEF_WIDTH
- NUM_TAPS, 8, maximum beats per accumulate group
- PIPE_STAGES, 3, product pipeline depth; legal range 2..4

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_data_vld  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  IN_DATA_WIDTH  unsigned sample
- coef  in  COEF_WIDTH  sign-magnitude coefficient
- in_last  in  1  last beat of an accumulate group (ignored in mode 0)
- mode  in  1  0 = per-beat product, 1 = accumulate group
- out_data  out  ACC_WIDTH  two's-complement result
- out_data_vld  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_count  out  $clog2(NUM_TAPS+1)  beats contained in result (1 in mode 0)
- out_ovf  out  1  signed overflow occurred during this result's accumulation

Behaviour:
- Beat accepted when in_data_vld && in_ready. in_ready = !(out_data_vld && !out_ready); a single global stall freezes every pipeline register and the accumulator.
- Product arithmetic:
  - mag = in_data * coef[COEF_WIDTH-2:0], width IN_DATA_WIDTH+COEF_WIDTH-1.
  - Product = sign ? -mag : mag, sign-extended to ACC_WIDTH.
  - Negative zero (sign=1, magnitude=0) yields exactly 0.
- Pipeline: stage 1 registers inputs, stage 2 multiplies, last stage negates and extends. Valid bits travel alongside the data.
- Mode 0: each beat produces one result with out_count=1 and out_ovf=0.
  - Latency: PIPE_STAGES+1 cycles from acceptance to out_data_vld, with no stall.
  - Throughput: one beat per cycle.
- Mode 1 accumulate group:
  - Mode is latched on the first beat of a group. Mode changes mid-group are ignored until the group closes.
  - Accumulator is cleared at the first beat (loaded with that product, not added).
  - Subsequent beats add their product modulo 2^ACC_WIDTH.
  - Group closes on the beat with in_last=1, or automatically on the NUM_TAPS-th beat, whichever comes first.
  - Result appears PIPE_STAGES+1 cycles after the closing beat is accepted, with out_count = number of beats.
  - The next group may start on the cycle after the closing beat.
- Overflow: each add checks two's-complement overflow (operands of the same sign, result of the opposite sign). The flag is sticky per group and reported as out_ovf with the result. The sum still wraps.
- Output register:
  - Holds out_data, out_count and out_ovf stable while out_data_vld && !out_ready.
  - Deasserts out_data_vld the cycle after the handshake unless a new result is loaded in the same cycle.
- Reset (synchronous, any time, including mid-group or mid-stall):
  - out_data=0, out_data_vld=0, out_count=0, out_ovf=0, in_ready=1.
  - All pipeline valids cleared, accumulator and tap counter cleared, group state returns to idle.
  - A partial group is discarded.
- in_last with in_data_vld=0 has no effect.

Decomposition:
- Shared package sm_mac_pkg:
  - Function sm_to_tc(magnitude, sign, width).
  - Derived localparams PROD_WIDTH = IN_DATA_WIDTH+COEF_WIDTH-1 and CNT_WIDTH.
  - Mode encoding constants MODE_PROD=0, MODE_ACC=1.
- One natural sub-module: sm_mult_pipe, the PIPE_STAGES-deep sign-magnitude multiplier with valid and stall enable.
- Top level holds the accumulator, group counter/FSM (IDLE, ACCUM) and output register.

Test Plan:
- Mode 0, in_data=131071, coef=131071 → out_data = −8589737985 (two's complement, 40 bits), out_count=1, PIPE_STAGES+1 cycles later.
- Mode 1, in_data=100, coefs 0x00003, 0x10005, 0x00007, 0x10001, in_last on 4th beat → out_data=400, out_count=4, out_ovf=0, one result only.
- Mode 1, 8 beats of in_data=1, coef=1, no in_last → auto-close with out_data=8, out_count=8. A 9th beat starts a new group.
- Mode 0, coef=0x10000 (negative zero), in_data=5 → out_data=0.
- Hold out_ready=0 for 5 cycles while a result is valid → in_ready=0 and out_data stable throughout. Streaming continues with no lost or duplicated beats after release.
- ACC_WIDTH=34, mode 1, two beats in_data=131071, coef=0x0FFFF → wrapped sum with out_ovf=1. Assert reset on the middle beat of a 3-beat group → all outputs 0 and no result emitted.
